// File: rtl/div_pkg.sv
// Shared types and sizing for the restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } div_state_t;

  localparam int DIV_W     = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 6;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial-subtract |b| from the shifted partial remainder.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_sh_i,
  input  logic [WIDTH-1:0] bmag_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  // Compare at WIDTH+1 bits so a shifted remainder above 2^WIDTH cannot wrap.
  assign q_bit_o = (rem_sh_i >= {1'b0, bmag_i});
  assign rem_o   = WIDTH'(q_bit_o ? (rem_sh_i - {1'b0, bmag_i}) : rem_sh_i);

endmodule

// File: rtl/div_unit.sv
// DIV/DIVU restoring divider, one quotient bit per cycle, 34-cycle back-to-back throughput.
// Optional DIV_BY_ZERO_FLAG_EN: div_by_zero output and a short path for a zero divisor.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W,
  parameter int ITERS = DIV_ITERS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
`ifdef DIV_BY_ZERO_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] a_q, a_d;
`endif

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic             a_neg;
  logic             b_neg;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_sh_i(({rem_q, quo_q[WIDTH-1]})),
    .bmag_i  (bmag_q),
    .rem_o   (step_rem),
    .q_bit_o (step_bit)
  );

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    bmag_d      = bmag_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = (state_q != IDLE);
    done_d      = 1'b0;
`ifdef DIV_BY_ZERO_FLAG_EN
    dbz_d       = dbz_q;
    a_d         = a_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          quo_d   = a_neg ? -dividend : dividend;
          bmag_d  = b_neg ? -divisor : divisor;
          sa_d    = a_neg;
          sb_d    = b_neg;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef DIV_BY_ZERO_FLAG_EN
          dbz_d   = (divisor == '0);
          a_d     = dividend;
`endif
        end
      end

      CALC: begin
`ifdef DIV_BY_ZERO_FLAG_EN
        // A zero divisor spends a single cycle here without iterating.
        if (dbz_q) begin
          state_d = FINISH;
        end else
`endif
        begin
          rem_d = step_rem;
          quo_d = {quo_q[WIDTH-2:0], step_bit};
          if (cnt_q == CNT_W'(ITERS - 1)) begin
            state_d = FINISH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      FINISH: begin
        quotient_d  = (sa_q ^ sb_q) ? -quo_q : quo_q;
        remainder_d = sa_q ? -rem_q : rem_q;
`ifdef DIV_BY_ZERO_FLAG_EN
        if (dbz_q) begin
          quotient_d  = '1;
          remainder_d = a_q;
        end
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      bmag_q      <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_BY_ZERO_FLAG_EN
      dbz_q       <= 1'b0;
      a_q         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      bmag_q      <= bmag_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DIV_BY_ZERO_FLAG_EN
      dbz_q       <= dbz_d;
      a_q         <= a_d;
`endif
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef DIV_BY_ZERO_FLAG_EN
  assign div_by_zero = dbz_q;
`endif

endmodule
